shift_word_serializer: RTL and testbench

- Downstream consumer of the parallel right-shift stage: accepts the WIDTH-bit shifted word and streams it out one bit per clock, LSB first.
- Uses a valid/ready input handshake and frame strobes so the serial sink knows where each word starts and ends.
- Drives the serial link and status strobes for the next stage in the shift datapath.

---
 rtl/shift_word_serializer.sv | 124 ++++++++++++
 tb/tb_shift_word_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_word_serializer.sv
// shift_word_serializer: LSB-first word serializer with valid/ready input and frame strobes.
// Define SER_PARITY_EN to append an even-parity bit after the data bits.
module shift_word_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
  state_t r_state, w_state;
  logic [WIDTH-1:0] r_shreg, w_shreg;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_ser_out, w_ser_out, r_ser_valid, w_ser_valid;
  logic r_frame_start, w_frame_start, r_frame_done, w_frame_done;
  logic r_busy, w_busy, r_din_ready, w_din_ready;
  logic w_accept;
`ifdef SER_PARITY_EN
  logic r_par, w_par;
`endif
  assign w_accept    = (r_state == IDLE) && din_valid && r_din_ready;
  assign din_ready   = r_din_ready;
  assign ser_out     = r_ser_out;
  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  always_comb begin
    w_state       = r_state;
    w_shreg       = r_shreg;
    w_cnt         = r_cnt;
    w_ser_out     = r_ser_out;
    w_ser_valid   = r_ser_valid;
    w_frame_start = 1'b0;
    w_frame_done  = 1'b0;
    w_busy        = r_busy;
    w_din_ready   = r_din_ready;
`ifdef SER_PARITY_EN
    w_par         = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_din_ready = !w_accept;
        if (w_accept) begin
          w_state       = SHIFT;
          w_shreg       = din;
          w_ser_out     = din[0];
          w_ser_valid   = 1'b1;
          w_frame_start = 1'b1;
          w_busy        = 1'b1;
          w_cnt         = '0;
`ifdef SER_PARITY_EN
          w_par         = ^din;
`endif
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SER_PARITY_EN
          w_state      = PARITY;
          w_ser_out    = r_par;
`else
          w_state      = DONE;
          w_ser_valid  = 1'b0;
          w_ser_out    = 1'b0;
          w_frame_done = 1'b1;
`endif
        end else begin
          w_shreg   = r_shreg >> 1;
          w_ser_out = r_shreg[1];
          w_cnt     = r_cnt + 1'b1;
        end
      end
      PARITY: begin
        w_state      = DONE;
        w_ser_valid  = 1'b0;
        w_ser_out    = 1'b0;
        w_frame_done = 1'b1;
      end
      default: begin
        w_state     = IDLE;
        w_busy      = 1'b0;
        w_din_ready = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_cnt         <= '0;
      r_ser_out     <= 1'b0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_din_ready   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_shreg       <= w_shreg;
      r_cnt         <= w_cnt;
      r_ser_out     <= w_ser_out;
      r_ser_valid   <= w_ser_valid;
      r_frame_start <= w_frame_start;
      r_frame_done  <= w_frame_done;
      r_busy        <= w_busy;
      r_din_ready   <= w_din_ready;
    end
  end
`ifdef SER_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_par <= 1'b0;
    else          r_par <= w_par;
  end
`endif
endmodule

// File: tb/tb_shift_word_serializer.sv
// tb_shift_word_serializer: directed-vector bench for shift_word_serializer (WIDTH=8).
// Build with +define+SER_PARITY_EN to exercise the parity variant.
module tb_shift_word_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FD  = W + (PAR ? 1 : 0);
  localparam int LAT = FD + 2;
  logic clk = 1'b0, reset_n = 1'b0, din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic din_ready, ser_out, ser_valid, frame_start, frame_done, busy;
  int passed = 0, total = 0;
  shift_word_serializer #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic wait_ready();
    int n = 0;
    din_valid = 1'b0;
    while (!din_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (din_ready !== 1'b1) $display("FAIL wait_ready: din_ready=%b required 1", din_ready);
    else passed++;
  endtask
  task automatic test_reset();
    logic [5:0] o;
    reset_n = 1'b0; din = 8'h55; din_valid = 1'b1;
    repeat (3) @(negedge clk);
    o = {din_ready, ser_out, ser_valid, frame_start, frame_done, busy};
    total++;
    if (o !== 6'b0) $display("FAIL reset_outputs: got %b required 000000", o); else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({din_ready, frame_start, busy} !== 3'b100)
      $display("FAIL reset_release: rdy/fs/busy=%b required 100", {din_ready, frame_start, busy});
    else passed++;
    @(negedge clk);
    total++;
    if ({frame_start, ser_out, ser_valid} !== 3'b111)
      $display("FAIL reset_first_accept: fs/so/sv=%b required 111", {frame_start, ser_out, ser_valid});
    else passed++;
    wait_ready();
  endtask
  task automatic test_frames();
    logic [W-1:0] words [5] = '{8'hFF, 8'hA5, 8'h07, 8'h03, 8'h3C};
    logic         pars  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] w;
    for (int t = 0; t < 5; t++) begin
      w = words[t];
      wait_ready();
      din = w; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0; din = ~w;
      total++;
      if ({frame_start, ser_valid, ser_out, busy, din_ready, frame_done} !== {1'b1, 1'b1, w[0], 1'b1, 1'b0, 1'b0})
        $display("FAIL frame_bit0 %h: fs/sv/so/busy/rdy/fd=%b required 11%b100", w,
                 {frame_start, ser_valid, ser_out, busy, din_ready, frame_done}, w[0]);
      else passed++;
      for (int i = 1; i < W; i++) begin
        @(negedge clk);
        total++;
        if ({ser_valid, ser_out, frame_start, frame_done, busy} !== {1'b1, w[i], 1'b0, 1'b0, 1'b1})
          $display("FAIL frame_bit%0d %h: sv/so/fs/fd/busy=%b required 1%b001", i, w,
                   {ser_valid, ser_out, frame_start, frame_done, busy}, w[i]);
        else passed++;
      end
      if (PAR) begin
        @(negedge clk);
        total++;
        if ({ser_valid, ser_out, frame_done} !== {1'b1, pars[t], 1'b0})
          $display("FAIL parity_bit %h: sv/so/fd=%b required 1%b0", w, {ser_valid, ser_out, frame_done}, pars[t]);
        else passed++;
      end
      @(negedge clk);
      total++;
      if ({ser_valid, ser_out, frame_done, busy, din_ready} !== 5'b00110)
        $display("FAIL frame_done %h: sv/so/fd/busy/rdy=%b required 00110", w,
                 {ser_valid, ser_out, frame_done, busy, din_ready});
      else passed++;
      @(negedge clk);
      total++;
      if ({frame_done, busy, din_ready} !== 3'b001)
        $display("FAIL frame_idle %h: fd/busy/rdy=%b required 001", w, {frame_done, busy, din_ready});
      else passed++;
    end
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] w2 = 8'h80;
    logic exp;
    wait_ready();
    din = 8'h01; din_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({frame_start, ser_out} !== 2'b11) $display("FAIL b2b_first: fs/so=%b required 11", {frame_start, ser_out});
    else passed++;
    din = w2;
    for (int j = 1; j < LAT; j++) begin
      @(negedge clk);
      exp = (PAR && j == W) ? 1'b1 : 1'b0;
      total++;
      if ({frame_start, ser_out} !== {1'b0, exp})
        $display("FAIL b2b_gap%0d: fs/so=%b required 0%b", j, {frame_start, ser_out}, exp);
      else passed++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    total++;
    if ({frame_start, ser_out, ser_valid} !== {1'b1, w2[0], 1'b1})
      $display("FAIL b2b_second_accept: fs/so/sv=%b required 1%b1", {frame_start, ser_out, ser_valid}, w2[0]);
    else passed++;
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      total++;
      if (ser_out !== w2[i]) $display("FAIL b2b_bit%0d: so=%b required %b", i, ser_out, w2[i]);
      else passed++;
    end
    wait_ready();
  endtask
  task automatic test_reset_mid();
    logic [W-1:0] w = 8'h3C;
    logic seen_fd = 1'b0;
    wait_ready();
    din = 8'hFF; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({din_ready, ser_out, ser_valid, frame_start, frame_done, busy} !== 6'b0)
      $display("FAIL reset_mid_async: got %b required 000000",
               {din_ready, ser_out, ser_valid, frame_start, frame_done, busy});
    else passed++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({din_ready, busy, frame_done} !== 3'b100)
      $display("FAIL reset_mid_release: rdy/busy/fd=%b required 100", {din_ready, busy, frame_done});
    else passed++;
    repeat (W + 2) begin
      @(negedge clk);
      if (frame_done) seen_fd = 1'b1;
    end
    total++;
    if (seen_fd !== 1'b0) $display("FAIL reset_mid_no_done: frame_done seen=%b required 0", seen_fd);
    else passed++;
    din = w; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    total++;
    if ({frame_start, ser_out} !== {1'b1, w[0]})
      $display("FAIL reset_mid_next_bit0: fs/so=%b required 1%b", {frame_start, ser_out}, w[0]);
    else passed++;
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      total++;
      if (ser_out !== w[i]) $display("FAIL reset_mid_next_bit%0d: so=%b required %b", i, ser_out, w[i]);
      else passed++;
    end
    wait_ready();
  endtask
  task automatic test_gating();
    wait_ready();
    din = 8'h0F; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (FD) @(negedge clk);
    total++;
    if ({frame_done, din_ready} !== 2'b10)
      $display("FAIL gating_done: fd/rdy=%b required 10", {frame_done, din_ready});
    else passed++;
    din = 8'h81; din_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({din_ready, frame_start, ser_valid} !== 3'b100)
      $display("FAIL gating_in_done: rdy/fs/sv=%b required 100", {din_ready, frame_start, ser_valid});
    else passed++;
    @(negedge clk);
    din_valid = 1'b0;
    total++;
    if ({frame_start, ser_out, din_ready} !== 3'b110)
      $display("FAIL gating_accept: fs/so/rdy=%b required 110", {frame_start, ser_out, din_ready});
    else passed++;
    wait_ready();
  endtask
  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_mid();
    test_gating();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
